// File: rtl/tlx_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlx_cmd_arbiter_pkg
// Description : Shared TLX command field widths, packed command record and
//               owner encoding for the rd/wr command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tlx_cmd_arbiter_pkg;

    localparam int OPC_W    = 8;
    localparam int AFUTAG_W = 16;
    localparam int EA_W     = 68;
    localparam int DL_W     = 2;
    localparam int PL_W     = 3;
    localparam int ACTAG_W  = 12;
    localparam int PASID_W  = 20;
    localparam int CMD_W    = OPC_W + AFUTAG_W + EA_W + DL_W + PL_W + ACTAG_W + PASID_W;

    localparam logic OWN_RD = 1'b0;
    localparam logic OWN_WR = 1'b1;

    typedef enum logic [0:0] {
        S_OWN_RD = OWN_RD,
        S_OWN_WR = OWN_WR
    } own_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]    opcode;
        logic [AFUTAG_W-1:0] afutag;
        logic [EA_W-1:0]     ea_or_obj;
        logic [DL_W-1:0]     dl;
        logic [PL_W-1:0]     pl;
        logic [ACTAG_W-1:0]  actag;
        logic [PASID_W-1:0]  pasid;
    } tlx_cmd_t;

endpackage
`default_nettype wire

// File: rtl/tlx_cmd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tlx_cmd_skid_buf
// Description : 2-entry FIFO holding one channel's TLX commands. Ready is
//               registered and reflects (occupancy < DEPTH) after each edge.
// Ports       : clk, rst_n        - clock, async active-low reset
//               valid/ready/data  - producer side; write on valid && ready
//               pop               - consumer removes head (only when not_empty)
//               not_empty/head    - consumer view of the oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module tlx_cmd_skid_buf
    import tlx_cmd_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [CMD_W-1:0] data,
    input  logic             pop,
    output logic             not_empty,
    output logic [CMD_W-1:0] head
);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;
    logic             w_push;
    logic [1:0]       w_count_nxt;

    assign w_push    = valid && r_ready;
    assign ready     = r_ready;
    assign not_empty = (r_count != 2'd0);
    assign head      = r_mem[r_rd_ptr];

    // Push and pop together leave occupancy unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < 2'(DEPTH));
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlx_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlx_cmd_arbiter
// Description : Weighted round-robin arbiter sharing the AFU->TLX command path
//               between the DMA read and write command channels. Each channel
//               has a 2-entry buffer; the winner is loaded into one registered
//               output stage that obeys tlx_cmd_s1_ready.
// Ports       : cfg_{rd,wr}_weight        - consecutive grants before yielding
//               {rd,wr}_cmd_valid/ready/* - channel command inputs
//               tlx_i_cmd_valid/*         - arbitrated command output
//               tlx_cmd_s1_ready          - downstream accept
//               arb_last_grant            - 0=rd, 1=wr of last loaded command
// Option      : TLX_CMD_ARB_GRANT_CNT_EN adds cfg_cnt_clr and saturating
//               per-channel grant counters rd_grant_cnt / wr_grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tlx_cmd_arbiter
    import tlx_cmd_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int WGT_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WGT_W-1:0]    cfg_rd_weight,
    input  logic [WGT_W-1:0]    cfg_wr_weight,
    input  logic                rd_cmd_valid,
    output logic                rd_cmd_ready,
    input  logic [OPC_W-1:0]    rd_cmd_opcode,
    input  logic [AFUTAG_W-1:0] rd_cmd_afutag,
    input  logic [EA_W-1:0]     rd_cmd_ea_or_obj,
    input  logic [DL_W-1:0]     rd_cmd_dl,
    input  logic [PL_W-1:0]     rd_cmd_pl,
    input  logic [ACTAG_W-1:0]  rd_cmd_actag,
    input  logic [PASID_W-1:0]  rd_cmd_pasid,
    input  logic                wr_cmd_valid,
    output logic                wr_cmd_ready,
    input  logic [OPC_W-1:0]    wr_cmd_opcode,
    input  logic [AFUTAG_W-1:0] wr_cmd_afutag,
    input  logic [EA_W-1:0]     wr_cmd_ea_or_obj,
    input  logic [DL_W-1:0]     wr_cmd_dl,
    input  logic [PL_W-1:0]     wr_cmd_pl,
    input  logic [ACTAG_W-1:0]  wr_cmd_actag,
    input  logic [PASID_W-1:0]  wr_cmd_pasid,
    output logic                tlx_i_cmd_valid,
    output logic [OPC_W-1:0]    tlx_i_cmd_opcode,
    output logic [AFUTAG_W-1:0] tlx_i_cmd_afutag,
    output logic [EA_W-1:0]     tlx_i_cmd_ea_or_obj,
    output logic [DL_W-1:0]     tlx_i_cmd_dl,
    output logic [PL_W-1:0]     tlx_i_cmd_pl,
    output logic [ACTAG_W-1:0]  tlx_i_cmd_actag,
    output logic [PASID_W-1:0]  tlx_i_cmd_pasid,
    input  logic                tlx_cmd_s1_ready,
`ifdef TLX_CMD_ARB_GRANT_CNT_EN
    input  logic                cfg_cnt_clr,
    output logic [31:0]         rd_grant_cnt,
    output logic [31:0]         wr_grant_cnt,
`endif
    output logic                arb_last_grant
);

    tlx_cmd_t         w_rd_in, w_wr_in, w_rd_head, w_wr_head, r_out;
    logic             w_rd_ne, w_wr_ne, w_pop_rd, w_pop_wr;
    logic             w_load, w_own, w_own_ne, w_oth_ne, w_sel;
    logic [WGT_W-1:0] w_wgt, w_lim, r_wcnt, w_wcnt_nxt;
    logic [WGT_W:0]   w_cnt_inc;
    logic             r_out_valid, r_last;
    own_state_e       r_state, w_state_nxt;

    assign w_rd_in = '{rd_cmd_opcode, rd_cmd_afutag, rd_cmd_ea_or_obj, rd_cmd_dl,
                       rd_cmd_pl, rd_cmd_actag, rd_cmd_pasid};
    assign w_wr_in = '{wr_cmd_opcode, wr_cmd_afutag, wr_cmd_ea_or_obj, wr_cmd_dl,
                       wr_cmd_pl, wr_cmd_actag, wr_cmd_pasid};

    tlx_cmd_skid_buf #(.DEPTH(BUF_DEPTH)) u_rd_buf (
        .clk(clk), .rst_n(rst_n), .valid(rd_cmd_valid), .ready(rd_cmd_ready),
        .data(w_rd_in), .pop(w_pop_rd), .not_empty(w_rd_ne), .head(w_rd_head)
    );

    tlx_cmd_skid_buf #(.DEPTH(BUF_DEPTH)) u_wr_buf (
        .clk(clk), .rst_n(rst_n), .valid(wr_cmd_valid), .ready(wr_cmd_ready),
        .data(w_wr_in), .pop(w_pop_wr), .not_empty(w_wr_ne), .head(w_wr_head)
    );

    assign w_load    = (!r_out_valid || tlx_cmd_s1_ready) && (w_rd_ne || w_wr_ne);
    assign w_own     = r_state;
    assign w_own_ne  = (w_own == OWN_RD) ? w_rd_ne : w_wr_ne;
    assign w_oth_ne  = (w_own == OWN_RD) ? w_wr_ne : w_rd_ne;
    // An empty owner never stalls the path: the other channel goes straight out.
    assign w_sel     = w_own_ne ? w_own : ~w_own;
    assign w_wgt     = (w_sel == OWN_WR) ? cfg_wr_weight : cfg_rd_weight;
    assign w_lim     = (w_wgt == '0) ? WGT_W'(1) : w_wgt;
    assign w_cnt_inc = {1'b0, r_wcnt} + (WGT_W+1)'(1);
    assign w_pop_rd  = w_load && (w_sel == OWN_RD);
    assign w_pop_wr  = w_load && (w_sel == OWN_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OWN_RD;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // >= rather than == so that lowering a weight mid-burst still yields.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        if (w_load) begin
            if (!w_own_ne) begin
                w_state_nxt = own_state_e'(w_sel);
                w_wcnt_nxt  = '0;
            end else if (w_cnt_inc >= {1'b0, w_lim}) begin
                w_wcnt_nxt = '0;
                if (w_oth_ne) begin
                    w_state_nxt = own_state_e'(~w_own);
                end
            end else begin
                w_wcnt_nxt = w_cnt_inc[WGT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_last      <= OWN_RD;
        end else if (w_load) begin
            r_out       <= (w_sel == OWN_WR) ? w_wr_head : w_rd_head;
            r_out_valid <= 1'b1;
            r_last      <= w_sel;
        end else if (tlx_cmd_s1_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign tlx_i_cmd_valid     = r_out_valid;
    assign tlx_i_cmd_opcode    = r_out.opcode;
    assign tlx_i_cmd_afutag    = r_out.afutag;
    assign tlx_i_cmd_ea_or_obj = r_out.ea_or_obj;
    assign tlx_i_cmd_dl        = r_out.dl;
    assign tlx_i_cmd_pl        = r_out.pl;
    assign tlx_i_cmd_actag     = r_out.actag;
    assign tlx_i_cmd_pasid     = r_out.pasid;
    assign arb_last_grant      = r_last;

`ifdef TLX_CMD_ARB_GRANT_CNT_EN
    logic [31:0] r_rd_cnt, r_wr_cnt;

    // Clear has priority over a same-cycle grant; counts saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (cfg_cnt_clr) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_pop_rd && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_pop_wr && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_grant_cnt = r_rd_cnt;
    assign wr_grant_cnt = r_wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlx_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlx_cmd_arbiter
// Description : Self-checking bench for tlx_cmd_arbiter: queue-based reference
//               model, grant-pattern table, directed corner cases and a
//               randomized phase. TLX_CMD_ARB_GRANT_CNT_EN enables the
//               grant counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlx_cmd_arbiter;
    import tlx_cmd_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] cfg_rd_weight, cfg_wr_weight;
    logic       rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
    tlx_cmd_t   rd_cmd, wr_cmd, got;
    logic       tlx_i_cmd_valid, tlx_cmd_s1_ready, arb_last_grant;
    logic [OPC_W-1:0]    o_opcode;
    logic [AFUTAG_W-1:0] o_afutag;
    logic [EA_W-1:0]     o_ea;
    logic [DL_W-1:0]     o_dl;
    logic [PL_W-1:0]     o_pl;
    logic [ACTAG_W-1:0]  o_actag;
    logic [PASID_W-1:0]  o_pasid;
    logic                cfg_cnt_clr;
`ifdef TLX_CMD_ARB_GRANT_CNT_EN
    logic [31:0]         rd_grant_cnt, wr_grant_cnt;
`endif

    assign got = {o_opcode, o_afutag, o_ea, o_dl, o_pl, o_actag, o_pasid};

    tlx_cmd_arbiter #(.BUF_DEPTH(2), .WGT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_rd_weight(cfg_rd_weight), .cfg_wr_weight(cfg_wr_weight),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_opcode(rd_cmd.opcode), .rd_cmd_afutag(rd_cmd.afutag),
        .rd_cmd_ea_or_obj(rd_cmd.ea_or_obj), .rd_cmd_dl(rd_cmd.dl), .rd_cmd_pl(rd_cmd.pl),
        .rd_cmd_actag(rd_cmd.actag), .rd_cmd_pasid(rd_cmd.pasid),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_opcode(wr_cmd.opcode), .wr_cmd_afutag(wr_cmd.afutag),
        .wr_cmd_ea_or_obj(wr_cmd.ea_or_obj), .wr_cmd_dl(wr_cmd.dl), .wr_cmd_pl(wr_cmd.pl),
        .wr_cmd_actag(wr_cmd.actag), .wr_cmd_pasid(wr_cmd.pasid),
        .tlx_i_cmd_valid(tlx_i_cmd_valid),
        .tlx_i_cmd_opcode(o_opcode), .tlx_i_cmd_afutag(o_afutag),
        .tlx_i_cmd_ea_or_obj(o_ea), .tlx_i_cmd_dl(o_dl), .tlx_i_cmd_pl(o_pl),
        .tlx_i_cmd_actag(o_actag), .tlx_i_cmd_pasid(o_pasid),
        .tlx_cmd_s1_ready(tlx_cmd_s1_ready),
`ifdef TLX_CMD_ARB_GRANT_CNT_EN
        .cfg_cnt_clr(cfg_cnt_clr), .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt),
`endif
        .arb_last_grant(arb_last_grant)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (queues + grant bookkeeping) ----------
    tlx_cmd_t    mq_rd[$], mq_wr[$];
    tlx_cmd_t    m_out;
    bit          m_rdy_rd, m_rdy_wr, m_valid, m_last, m_owner;
    int          m_streak;           // grants given to the owner in its current turn
    logic [31:0] m_rd_cnt, m_wr_cnt;
    bit          pushed_rd, pushed_wr;
    logic [15:0] rd_tag, wr_tag;

    function automatic tlx_cmd_t mk(input logic [15:0] tag);
        tlx_cmd_t c;
        c.opcode    = 8'($urandom);
        c.afutag    = tag;
        c.ea_or_obj = {4'($urandom), $urandom, $urandom};
        c.dl        = 2'($urandom);
        c.pl        = 3'($urandom);
        c.actag     = 12'($urandom);
        c.pasid     = 20'($urandom);
        return c;
    endfunction

    function automatic int eff_w(input logic [3:0] w);
        return (w == 4'd0) ? 1 : int'(w);
    endfunction

    task automatic model_reset();
        mq_rd.delete(); mq_wr.delete();
        m_out = '0; m_rdy_rd = 0; m_rdy_wr = 0; m_valid = 0; m_last = 0;
        m_owner = 0; m_streak = 0; m_rd_cnt = 0; m_wr_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        chk_b({tag, "_valid"}, tlx_i_cmd_valid, m_valid);
        chk_b({tag, "_rd_rdy"}, rd_cmd_ready, m_rdy_rd);
        chk_b({tag, "_wr_rdy"}, wr_cmd_ready, m_rdy_wr);
        chk_b({tag, "_last"}, arb_last_grant, m_last);
        chk_w({tag, "_fields"}, 192'(got), 192'(m_out));
`ifdef TLX_CMD_ARB_GRANT_CNT_EN
        chk_w({tag, "_rd_cnt"}, 192'(rd_grant_cnt), 192'(m_rd_cnt));
        chk_w({tag, "_wr_cnt"}, 192'(wr_grant_cnt), 192'(m_wr_cnt));
`endif
    endtask

    // One clock: predict from current inputs, clock, then compare.
    task automatic step();
        bit load, sel, other_ne;
        tlx_cmd_t h;
        pushed_rd = rd_cmd_valid && m_rdy_rd;
        pushed_wr = wr_cmd_valid && m_rdy_wr;
        load = (!m_valid || tlx_cmd_s1_ready) && (mq_rd.size() > 0 || mq_wr.size() > 0);
        if (load) begin
            if (m_owner == 0) sel = (mq_rd.size() > 0) ? 1'b0 : 1'b1;
            else              sel = (mq_wr.size() > 0) ? 1'b1 : 1'b0;
            other_ne = sel ? (mq_rd.size() > 0) : (mq_wr.size() > 0);
            if (sel != m_owner) begin
                m_owner  = sel;
                m_streak = 0;
            end else if (m_streak + 1 >= eff_w(sel ? cfg_wr_weight : cfg_rd_weight)) begin
                m_streak = 0;
                if (other_ne) m_owner = !sel;
            end else begin
                m_streak = m_streak + 1;
            end
            h = sel ? mq_wr.pop_front() : mq_rd.pop_front();
            m_out = h; m_valid = 1; m_last = sel;
        end else if (tlx_cmd_s1_ready) begin
            m_valid = 0;
        end
        if (cfg_cnt_clr) begin
            m_rd_cnt = 0; m_wr_cnt = 0;
        end else if (load) begin
            if (!sel && m_rd_cnt != 32'hFFFF_FFFF) m_rd_cnt = m_rd_cnt + 1;
            if ( sel && m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt = m_wr_cnt + 1;
        end
        if (pushed_rd) mq_rd.push_back(rd_cmd);
        if (pushed_wr) mq_wr.push_back(wr_cmd);
        m_rdy_rd = mq_rd.size() < 2;
        m_rdy_wr = mq_wr.size() < 2;
        @(posedge clk);
        #1;
        compare_all("cyc");
        if (pushed_rd) begin rd_tag = rd_tag + 16'd1; rd_cmd = mk(rd_tag); end
        if (pushed_wr) begin wr_tag = wr_tag + 16'd1; wr_cmd = mk(wr_tag); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_cmd_valid = 0; wr_cmd_valid = 0; tlx_cmd_s1_ready = 0; cfg_cnt_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- grant-pattern table ----------------
    typedef struct {
        logic [3:0] rdw;
        logic [3:0] wrw;
        logic [7:0] exp_seq;   // bit i = channel of i-th grant
    } wrr_vec_t;

    wrr_vec_t vecs[4];
    logic [7:0] seen;
    int         nseen, npush;
    logic [15:0] base;
    tlx_cmd_t   held;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd3, 4'd1, 8'b1000_1000};
        vecs[1] = '{4'd0, 4'd0, 8'b1010_1010};
        vecs[2] = '{4'd1, 4'd2, 8'b1011_0110};
        vecs[3] = '{4'd2, 4'd3, 8'b1001_1100};

        rd_tag = 16'h0000; wr_tag = 16'h8000;
        rd_cmd = mk(rd_tag); wr_cmd = mk(wr_tag);
        cfg_rd_weight = 4'd1; cfg_wr_weight = 4'd1;

        // Table: both channels streaming, downstream always ready.
        for (int v = 0; v < 4; v++) begin
            cfg_rd_weight = vecs[v].rdw; cfg_wr_weight = vecs[v].wrw;
            do_reset();
            tlx_cmd_s1_ready = 1; rd_cmd_valid = 1; wr_cmd_valid = 1;
            nseen = 0; seen = '0;
            for (int c = 0; c < 40 && nseen < 8; c++) begin
                step();
                if (tlx_i_cmd_valid) begin
                    seen[nseen] = arb_last_grant;
                    nseen++;
                end
            end
            chk_w($sformatf("wrr_seq_%0d", v), 192'(seen), 192'(vecs[v].exp_seq));
        end

        // Reset asserted while a command sits in the output stage.
        cfg_rd_weight = 4'd2; cfg_wr_weight = 4'd2;
        do_reset();
        rd_cmd_valid = 1; wr_cmd_valid = 0;
        repeat (3) step();
        chk_b("pre_rst_valid", tlx_i_cmd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_b("rst_valid", tlx_i_cmd_valid, 1'b0);
        chk_b("rst_rd_rdy", rd_cmd_ready, 1'b0);
        chk_b("rst_wr_rdy", wr_cmd_ready, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_cmd_valid = 0;
        step();
        tlx_cmd_s1_ready = 1; rd_cmd_valid = 1;
        base = rd_cmd.afutag;
        step();
        rd_cmd_valid = 0;
        step();
        chk_b("rst_lat_valid", tlx_i_cmd_valid, 1'b1);
        chk_w("rst_lat_tag", 192'(o_afutag), 192'(base));
        step();
        chk_b("rst_lat_drop", tlx_i_cmd_valid, 1'b0);

        // Downstream stalled, three rd pushes, then drain.
        cfg_rd_weight = 4'd1; cfg_wr_weight = 4'd1;
        do_reset();
        tlx_cmd_s1_ready = 0; rd_cmd_valid = 1; npush = 0;
        base = rd_tag;
        for (int i = 0; i < 10 && npush < 3; i++) begin
            step();
            if (pushed_rd) npush++;
        end
        rd_cmd_valid = 0;
        chk_w("stall_pushes", 192'(npush), 192'(3));
        chk_b("stall_rd_rdy", rd_cmd_ready, 1'b0);
        chk_w("stall_head", 192'(o_afutag), 192'(base));
        held = got;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_w("stall_hold", 192'(got), 192'(held));
        end
        tlx_cmd_s1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk_b("drain_valid", tlx_i_cmd_valid, 1'b1);
            chk_w("drain_tag", 192'(o_afutag), 192'(16'(base + 16'(i))));
            step();
        end
        chk_b("drain_done", tlx_i_cmd_valid, 1'b0);

        // wr-only traffic while rd owns: no bubble, ownership moves to wr.
        cfg_rd_weight = 4'd2; cfg_wr_weight = 4'd2;
        do_reset();
        tlx_cmd_s1_ready = 1; wr_cmd_valid = 1;
        step();
        wr_cmd_valid = 0;
        step();
        chk_b("wronly_valid", tlx_i_cmd_valid, 1'b1);
        chk_b("wronly_grant", arb_last_grant, 1'b1);
        repeat (2) step();
        rd_cmd_valid = 1; wr_cmd_valid = 1;
        step();
        rd_cmd_valid = 0; wr_cmd_valid = 0;
        step();
        chk_b("owner_wr_wins", arb_last_grant, 1'b1);
        step();
        chk_b("then_rd", arb_last_grant, 1'b0);

`ifdef TLX_CMD_ARB_GRANT_CNT_EN
        // Grant counters: 5 rd and 2 wr, then clear coinciding with a grant.
        do_reset();
        tlx_cmd_s1_ready = 1; rd_cmd_valid = 1; npush = 0;
        for (int i = 0; i < 20 && npush < 5; i++) begin step(); if (pushed_rd) npush++; end
        rd_cmd_valid = 0; wr_cmd_valid = 1; npush = 0;
        for (int i = 0; i < 20 && npush < 2; i++) begin step(); if (pushed_wr) npush++; end
        wr_cmd_valid = 0;
        repeat (4) step();
        chk_w("cnt_rd5", 192'(rd_grant_cnt), 192'(5));
        chk_w("cnt_wr2", 192'(wr_grant_cnt), 192'(2));
        rd_cmd_valid = 1;
        step();
        rd_cmd_valid = 0; cfg_cnt_clr = 1;
        step();
        cfg_cnt_clr = 0;
        chk_b("clr_grant_seen", tlx_i_cmd_valid, 1'b1);
        chk_w("clr_rd", 192'(rd_grant_cnt), 192'(0));
        chk_w("clr_wr", 192'(wr_grant_cnt), 192'(0));
`endif

        // Randomized traffic, back-pressure and weight changes.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rd_cmd_valid     = ($urandom_range(0, 3) != 0);
            wr_cmd_valid     = ($urandom_range(0, 3) != 0);
            tlx_cmd_s1_ready = ($urandom_range(0, 3) != 0);
`ifdef TLX_CMD_ARB_GRANT_CNT_EN
            cfg_cnt_clr      = ($urandom_range(0, 63) == 0);
`endif
            if (c % 50 == 0) begin
                cfg_rd_weight = 4'($urandom_range(0, 15));
                cfg_wr_weight = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlx_cmd_arbiter.md
Name: tlx_cmd_arbiter

Overview:
- Shares the single AFU→TLX command path between two requesters: the read-command channel (rd) and the write-command channel (wr) of the DMA engine.
- Each channel has a 2-entry input buffer. A weighted round-robin (WRR) scheduler picks between the buffers and drives one registered command stage.
- That stage feeds the context/acTag surveillance stage through its tlx_i_cmd_* inputs and obeys its tlx_cmd_s1_ready.

Parameters:
- BUF_DEPTH, 2, entries per channel buffer. Fixed at 2; the pointer logic is sized for 2.
- WGT_W, 4, width of the per-channel weight fields.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cfg_rd_weight  in  WGT_W  consecutive grants allowed to rd before yielding; 0 is treated as 1
- cfg_wr_weight  in  WGT_W  consecutive grants allowed to wr before yielding; 0 is treated as 1
- rd_cmd_valid  in  1  rd command valid
- rd_cmd_ready  out  1  rd buffer can accept
- rd_cmd_{opcode,afutag,ea_or_obj,dl,pl,actag,pasid}  in  8,16,68,2,3,12,20  rd command fields
- wr_cmd_valid  in  1  wr command valid
- wr_cmd_ready  out  1  wr buffer can accept
- wr_cmd_{opcode,afutag,ea_or_obj,dl,pl,actag,pasid}  in  8,16,68,2,3,12,20  wr command fields
- tlx_i_cmd_valid  out  1  arbitrated command valid
- tlx_i_cmd_{opcode,afutag,ea_or_obj,dl,pl,actag,pasid}  out  8,16,68,2,3,12,20  arbitrated command fields
- tlx_cmd_s1_ready  in  1  downstream accepts when high together with tlx_i_cmd_valid
- arb_last_grant  out  1  channel of the last command loaded into the output stage: 0=rd, 1=wr

Behaviour:
- Reset: rd_cmd_ready=0, wr_cmd_ready=0, tlx_i_cmd_valid=0, all tlx_i_cmd_* fields=0, arb_last_grant=0, buffers empty, weight counter=0, owner=rd.
- First cycle after reset release: both ready=1.
- Input handshake: a command is written when x_cmd_valid && x_cmd_ready. x_cmd_ready is registered and equals (occupancy<2) after the edge.
  - Simultaneous push and pop with occupancy 2 is not allowed, because ready is already 0.
  - Push and pop in the same cycle at occupancy 1 keeps occupancy at 1.
- Buffer ordering: strict FIFO per channel. Pointers are 1 bit and wrap 1→0.
- Output stage:
  - Load condition: load = (!tlx_i_cmd_valid || tlx_cmd_s1_ready) && (either buffer non-empty).
  - On load, the selected head is popped and copied into the output register, tlx_i_cmd_valid=1, and arb_last_grant is updated.
  - If load=0 and tlx_cmd_s1_ready=1, tlx_i_cmd_valid drops to 0.
  - While tlx_i_cmd_valid=1 and tlx_cmd_s1_ready=0, all fields are held stable.
- Latency: an input accepted at edge N makes tlx_i_cmd_valid=1 at edge N+1 if the path is idle. Sustained throughput is 1 command/cycle.
- WRR scheduler, 2-state FSM {OWN_RD, OWN_WR} with counter wcnt[WGT_W-1:0]:
  - The owner is selected if its buffer is non-empty. Otherwise the other channel is selected and ownership switches immediately with wcnt reset.
  - On each load from the owner, wcnt+1. When wcnt+1 reaches max(weight,1) and the other buffer is non-empty, ownership switches and wcnt=0.
  - When wcnt+1 reaches max(weight,1) and the other buffer is empty, ownership is kept and wcnt=0.
  - Weights are sampled at each grant. A weight change mid-burst takes effect on the next comparison.
- Both channels arriving at the same time after idle: the current owner wins. After reset the owner is rd.
- No command is ever dropped or duplicated. Per-channel order is preserved. Cross-channel order follows grant order.

Optional Feature:
- Macro: TLX_CMD_ARB_GRANT_CNT_EN.
- Defined: adds input cfg_cnt_clr (1) and outputs rd_grant_cnt (32) and wr_grant_cnt (32).
  - Counters count output-stage loads per channel and saturate at 0xFFFF_FFFF.
  - Counters are synchronously cleared when cfg_cnt_clr=1; clear wins over a simultaneous increment.
  - Reset value is 0.
- Undefined: these ports and counters are absent; there is no other behavioural change.

Decomposition:
- Shared package:
  - TLX command field width constants: OPC_W=8, AFUTAG_W=16, EA_W=68, DL_W=2, PL_W=3, ACTAG_W=12, PASID_W=20.
  - CMD_W as their sum (129).
  - Owner encoding constants OWN_RD=0 and OWN_WR=1.
- One natural sub-module: tlx_cmd_skid_buf, a 2-entry FIFO of CMD_W bits with registered ready. It is instantiated once per channel.

Test Plan:
- Reset mid-traffic: assert rst_n=0 while tlx_i_cmd_valid=1 → same cycle tlx_i_cmd_valid=0 and both ready=0; after release, buffers are empty and the next command has a 1-cycle latency.
- Weights rd=3, wr=1, both channels streaming, tlx_cmd_s1_ready=1 → arb_last_grant sequence 0,0,0,1,0,0,0,1; every afutag appears exactly once and in order per channel.
- Weight 0 on both channels, both streaming → strict alternation 0,1,0,1.
- tlx_cmd_s1_ready=0 for 10 cycles with 3 rd pushes → rd_cmd_ready=0 after the 3rd push (1 command in the output stage plus 2 buffered); fields stay stable; on ready=1, 3 commands drain on consecutive cycles.
- Only wr traffic with owner=rd → wr is granted in the first cycle with no idle bubble; the owner switches to OWN_WR.
- With TLX_CMD_ARB_GRANT_CNT_EN: 5 rd and 2 wr grants → rd_grant_cnt=5, wr_grant_cnt=2; cfg_cnt_clr pulse in the same cycle as a grant → counters read 0.
